// File: rtl/des_pkg.sv
// des_pkg: shared tables, types and pure functions for the iterative DES core.
// Bit numbering follows the DES standard: table entry n refers to bit n of
// the source, where bit 1 is the MSB.
package des_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

   localparam int FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
      34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};

   localparam int E_T [48] = '{
      32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
      12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
      24,25,26,27,28,29, 28,29,30,31,32, 1};

   localparam int P_T [32] = '{
      16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
       2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};

   localparam int PC1_T [56] = '{
      57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
      10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
      63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
      14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};

   localparam int PC2_T [48] = '{
      14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8,
      16, 7,27,20,13, 2, 41,52,31,37,47,55, 30,40,51,45,33,48,
      44,49,39,56,34,53, 46,42,50,36,29,32};

   // Total left rotation of C/D after rounds 1..16, so any round key can be
   // produced directly from PC1(key).
   localparam int SHIFT_CUM [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};

   // S1..S8 back to back, 64 entries each, row-major (row = b1b6, col = b2..b5).
   localparam int SBOX [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   function automatic logic [63:0] ip(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
      return o;
   endfunction

   function automatic logic [63:0] fp(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
      return o;
   endfunction

   // Parity bits (8, 16, ... 64) are simply never selected.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] o;
      for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
      return o;
   endfunction

   function automatic logic [47:0] round_key(input logic [55:0] cd56, input logic [3:0] idx);
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] o;
      int          sh;
      sh = SHIFT_CUM[idx];
      c  = cd56[55:28];
      d  = cd56[27:0];
      c  = (c << sh) | (c >> (28 - sh));
      d  = (d << sh) | (d >> (28 - sh));
      cd = {c, d};
      for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
      return o;
   endfunction

   function automatic logic [31:0] feistel_f(input logic [31:0] r32, input logic [47:0] k48);
      logic [47:0] x;
      logic [31:0] s;
      logic [31:0] o;
      logic [5:0]  six;
      for (int i = 0; i < 48; i++) x[47-i] = r32[32-E_T[i]];
      x = x ^ k48;
      for (int b = 0; b < 8; b++) begin
         six = x[47-6*b -: 6];
         s[31-4*b -: 4] = 4'(SBOX[b*64 + 16*int'({six[5], six[0]}) + int'(six[4:1])]);
      end
      for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
      return o;
   endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational Feistel round.
//   l, r     in  32  round input halves
//   k        in  48  round key
//   l_next   out 32  = r
//   r_next   out 32  = l ^ f(r, k)
module des_round
   import des_pkg::*;
(
   input  logic [31:0] l,
   input  logic [31:0] r,
   input  logic [47:0] k,
   output logic [31:0] l_next,
   output logic [31:0] r_next
);

   assign l_next = r;
   assign r_next = l ^ feistel_f(r, k);

endmodule

// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES / TDES-EDE engine, ROUNDS_PER_CYCLE rounds per
// clock, one block in flight, valid/ready on both sides.
//   clk, rst_n            core clock, async active-low reset
//   in_valid/in_ready     input handshake (ready only in IDLE)
//   in_text[64]           block, in_key[192] = {K1,K2,K3}
//   in_decrypt, in_tdes   direction, TDES-EDE select
//   out_valid/out_ready   output handshake, out_text[64] held while stalled
//   busy                  high in RUN or DONE
module des_iter_core
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int TDES_EN          = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_text,
   input  logic [191:0] in_key,
   input  logic         in_decrypt,
   input  logic         in_tdes,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_text,
   output logic         busy
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
         ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
      $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Step truncates to 0 for 16 rounds/clock: the counter then stays at 0 and
   // every clock is the last step of a pass.
   localparam logic [3:0] RSTEP    = 4'(ROUNDS_PER_CYCLE);
   localparam logic [3:0] LAST_RND = 4'(16 - ROUNDS_PER_CYCLE);

   state_t        state, state_nxt;
   logic [31:0]   l_q, r_q;
   logic [191:0]  key_q;
   logic          dec_q, tdes_q;
   logic [1:0]    pass_q;
   logic [3:0]    round_q;
   logic [63:0]   out_q;

   logic [63:0]   pass_key;
   logic [55:0]   cd;
   logic          pass_dec, last_step, last_pass;
   logic [31:0]   l_fin, r_fin;

   // EDE: middle pass runs opposite to the requested direction; decrypt walks
   // the keys K3, K2, K1.
   always_comb begin
      pass_key = key_q[191:128];
      if (pass_q == 2'd1)
         pass_key = key_q[127:64];
      else if ((pass_q == 2'd0 && tdes_q && dec_q) || (pass_q == 2'd2 && !dec_q))
         pass_key = key_q[63:0];
   end

   assign cd        = pc1(pass_key);
   assign pass_dec  = dec_q ^ (pass_q == 2'd1);
   assign last_step = (round_q == LAST_RND);
   assign last_pass = !tdes_q || (pass_q == 2'd2);

   for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
      logic [31:0] l_i, r_i, l_o, r_o;
      logic [3:0]  idx;
      logic [47:0] k;
      if (j == 0) begin : g_head
         assign l_i = l_q;
         assign r_i = r_q;
      end else begin : g_link
         assign l_i = g_rnd[j-1].l_o;
         assign r_i = g_rnd[j-1].r_o;
      end
      assign idx = round_q + 4'(j);
      assign k   = round_key(cd, pass_dec ? (4'd15 - idx) : idx);
      des_round u_round (.l(l_i), .r(r_i), .k(k), .l_next(l_o), .r_next(r_o));
   end

   assign l_fin = g_rnd[ROUNDS_PER_CYCLE-1].l_o;
   assign r_fin = g_rnd[ROUNDS_PER_CYCLE-1].r_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last_step && last_pass) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_q     <= '0;
         r_q     <= '0;
         key_q   <= '0;
         dec_q   <= 1'b0;
         tdes_q  <= 1'b0;
         pass_q  <= '0;
         round_q <= '0;
         out_q   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               {l_q, r_q} <= ip(in_text);
               key_q      <= in_key;
               dec_q      <= in_decrypt;
               tdes_q     <= (TDES_EN != 0) && in_tdes;
               pass_q     <= '0;
               round_q    <= '0;
            end
            RUN: begin
               round_q <= round_q + RSTEP;
               if (!last_step) begin
                  l_q <= l_fin;
                  r_q <= r_fin;
               end else if (last_pass) begin
                  out_q <= fp({r_fin, l_fin});
               end else begin
                  // FP then IP cancel, so the swapped halves feed the next pass.
                  pass_q <= pass_q + 2'd1;
                  l_q    <= r_fin;
                  r_q    <= l_fin;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign out_text  = out_q;

endmodule

// File: doc/des_iter_core.md
Name: des_iter_core

Overview:
- Sequential, parametrised successor to the combinational DES datapath.
- Iterates ROUNDS_PER_CYCLE Feistel rounds per clock over 16 rounds; optionally chains three passes for TDES-EDE.
- Valid/ready handshake on input and output, one block in flight.
- Sits between the host block buffer and the cipher output path; replaces the 16-round unrolled stack where area matters.

Parameters:
- ROUNDS_PER_CYCLE, 1, Feistel rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- TDES_EN, 1, 1 instantiates triple-DES support; 0 forces single DES and ties in_tdes to 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block/key/mode present
- in_ready  out  1  core can accept (high only in IDLE)
- in_text  in  64  plain or cipher text block
- in_key  in  192  K1=[191:128], K2=[127:64], K3=[63:0]; parity bits present and ignored
- in_decrypt  in  1  0 encrypt, 1 decrypt
- in_tdes  in  1  1 selects TDES-EDE, 0 single DES using K1
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_text  out  64  result block
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE, out_valid=0, out_text=0, busy=0, in_ready=1 once rst_n is high.
  - All counters and the L/R/C/D registers are cleared.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture IP(in_text) into L/R, capture keys/mode/tdes, set pass=0, round=0, go to RUN.
  - RUN: each clock applies ROUNDS_PER_CYCLE rounds, round += ROUNDS_PER_CYCLE (4-bit, wraps to 0 at 16).
    - On wrap with more passes pending: pass++; next pass takes (R16,L16) directly as (L0,R0), since FP followed by IP is identity.
    - On wrap of the last pass: out_text = FP(R16,L16), out_valid=1, go to DONE.
  - DONE: out_valid=1. out_text is held stable while !out_ready. On out_ready, out_valid=0, go to IDLE in the same edge.
- Pass count is 1 for single DES, 3 for TDES. Key and direction per pass:
  - Encrypt TDES: pass0 enc K1, pass1 dec K2, pass2 enc K3.
  - Decrypt TDES: pass0 dec K3, pass1 enc K2, pass2 dec K1.
  - Single DES: pass0 uses K1 with the in_decrypt direction.
- Round key generation:
  - Combinational from PC1(pass key), rotated by the cumulative shift table, then PC2.
  - Indexed by round (encrypt) or 15-round (decrypt), so no rolling key state is needed.
- Latency: out_valid rises exactly P*16/ROUNDS_PER_CYCLE clocks after the accepting edge, with P = 1 or 3.
  - Example: R=1 gives 16 (DES) or 48 (TDES).
  - Example: R=16 gives 1 (DES) or 3 (TDES).
- Throughput: no new accept before the output handshake. in_ready stays low in RUN and DONE; in_valid is ignored there.
- The earliest next accept is the clock after out_valid&&out_ready.
- Inputs are sampled only on the accept edge. Later changes to in_text or in_key do not affect the block in flight.
- Asserting rst_n low mid-RUN or mid-DONE aborts the block; no partial output is ever presented.
- Weak and semi-weak keys are not detected.

Decomposition:
- des_pkg holds:
  - IP, FP, E, P, PC1 and PC2 permutation tables, plus the eight S-boxes.
  - The cumulative left-shift table.
  - The state enum (IDLE, RUN, DONE).
  - Functions: ip, fp, pc1, round_key(cd56, idx), feistel_f(r32, k48).
- One sub-module, des_round: one Feistel round, (L,R,K48) -> (L',R'), purely combinational.
  - It is instantiated ROUNDS_PER_CYCLE times in a generate chain, with keys idx, idx+1, ... in the direction of the pass.

Test Plan:
- R=1, DES encrypt: K1=133457799BBCDFF1, text 0123456789ABCDEF -> out_text 85E813540F0AB405; out_valid exactly 16 clocks after accept.
- DES decrypt with the same key, text 85E813540F0AB405 -> 0123456789ABCDEF. Repeat for R=2,4,8,16 with latencies 8, 4, 2, 1.
- TDES encrypt with K1=K2=K3=133457799BBCDFF1, text 0123456789ABCDEF -> 85E813540F0AB405 after 48/R clocks. Distinct K1/K2/K3 must round-trip through TDES decrypt back to the original text.
- Backpressure: hold out_ready=0 for 10 clocks after out_valid -> out_text stable, in_ready=0, in_valid pulses ignored. On out_ready=1: out_valid falls, in_ready=1 on the next clock, and a back-to-back accept succeeds.
- Reset mid-run: assert rst_n low at round 7 -> out_valid=0 and out_text=0 immediately. After release, in_ready=1 and a fresh block produces the correct result.
- TDES_EN=0 build: in_tdes=1 with the first test's vectors -> single-DES result 85E813540F0AB405 with 16/R latency.
